// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM: IF fetch (port 0) and MEM load/store (port 1).
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate winner on conflicts; default is fixed MEM>IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       owner, owner_next;   // 0 = IF, 1 = MEM
  logic       store, store_next;
  logic       armed;               // holds off arbitration in the first cycle after reset release
  logic       done, can_issue, pick_mem;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic       last_grant, last_grant_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      store      <= 1'b0;
      armed      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      owner      <= owner_next;
      store      <= store_next;
      armed      <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    owner_next = owner;
    store_next = store;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_next = last_grant;
`endif
    if_gnt     = 1'b0;
    mem_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    mem_rvalid = 1'b0;
    if_rdata   = '0;
    mem_rdata  = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    done = (state == WAIT) && (cnt == 4'd1);
    busy = (state == WAIT);

    if (state == WAIT) begin
      if (done) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt - 4'd1;
      end
    end

    if_rvalid  = done && !owner;
    mem_rvalid = done && owner;
    if (if_rvalid)
      if_rdata = ram_rdata;
    if (mem_rvalid && !store)
      mem_rdata = ram_rdata;

    // The completion cycle doubles as an arbitration cycle for back-to-back issue.
    can_issue = armed && ((state == IDLE) || done);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_mem = mem_req && (!if_req || !last_grant);
`else
    pick_mem = mem_req;
`endif

    if (can_issue && (if_req || mem_req)) begin
      state_next = WAIT;
      cnt_next   = LAT;
      owner_next = pick_mem;
      store_next = pick_mem && mem_we;
      ram_en     = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_next = pick_mem;
`endif
      if (pick_mem) begin
        mem_gnt   = 1'b1;
        ram_we    = mem_we;
        ram_addr  = mem_addr;
        ram_wdata = mem_wdata;
      end else begin
        if_gnt   = 1'b1;
        ram_addr = if_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 3) share stimulus, each with its own RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [63:0] if_addr, mem_addr, mem_wdata;

  // {busy, ram_en, ram_we, if_gnt, if_rvalid, mem_gnt, mem_rvalid}
  logic [6:0]  flags    [1:3];
  logic [63:0] if_rd    [1:3];
  logic [63:0] mem_rd   [1:3];
  logic [63:0] r_addr   [1:3];
  logic [63:0] r_wdata  [1:3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar k = 1; k <= 3; k++) begin : g
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en, ram_we, busy;
    logic [63:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [63:0] mem  [0:511];
    logic [63:0] pipe [0:2];

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(k)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
    );

    initial begin
      for (int j = 0; j < 512; j++) mem[j] = 64'hC0DE_0000 + 64'(j);
      mem[8]  = 64'h00A0_0093;
      mem[16] = 64'h1111_2222;
      for (int j = 0; j < 3; j++) pipe[j] = '0;
    end

    // Read-before-write RAM with a k-deep read pipeline.
    always @(posedge clk) begin
      if (ram_en) begin
        pipe[0] <= mem[ram_addr[11:3]];
        if (ram_we) mem[ram_addr[11:3]] <= ram_wdata;
      end
      for (int j = 1; j < 3; j++) pipe[j] <= pipe[j-1];
    end

    assign ram_rdata  = pipe[k-1];
    assign flags[k]   = {busy, ram_en, ram_we, if_gnt, if_rvalid, mem_gnt, mem_rvalid};
    assign if_rd[k]   = if_rdata;
    assign mem_rd[k]  = mem_rdata;
    assign r_addr[k]  = ram_addr;
    assign r_wdata[k] = ram_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_flags(input string tag, input int k, input logic [6:0] exp);
    check(tag, 64'(flags[k]), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    if_req  = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) check_flags("rst_flags", k, 7'b0);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check_flags("rst_release", 2, 7'b0);
    tick();
  endtask

  logic w, prev;

  initial begin
    // Test 1: single fetch, MEM_LAT=2 (also observed on LAT 1 and 3)
    do_reset();
    if_req = 1'b1; if_addr = 64'h40;
    @(negedge clk);
    check_flags("t1_grant", 2, 7'b0101000);
    check("t1_addr", r_addr[2], 64'h40);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check_flags("t1_wait", 2, 7'b1000000);
    check_flags("t1_lat1_rv", 1, 7'b1000100);
    check("t1_lat1_data", if_rd[1], 64'h00A0_0093);
    tick();
    @(negedge clk);
    check_flags("t1_rvalid", 2, 7'b1000100);
    check("t1_rdata", if_rd[2], 64'h00A0_0093);
    check_flags("t1_lat3_wait", 3, 7'b1000000);
    tick();
    @(negedge clk);
    check_flags("t1_done", 2, 7'b0);
    check("t1_rdata_zero", if_rd[2], 64'h0);
    check_flags("t1_lat3_rv", 3, 7'b1000100);

    // Test 2: simultaneous requests, MEM wins, back-to-back IF
    do_reset();
    if_req = 1'b1; if_addr = 64'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h200;
    @(negedge clk);
    check_flags("t2_mem_gnt", 2, 7'b0100010);
    check("t2_addr0", r_addr[2], 64'h200);
    tick();
    mem_req = 1'b0;
    @(negedge clk);
    check_flags("t2_wait0", 2, 7'b1000000);
    tick();
    @(negedge clk);
    check_flags("t2_handoff", 2, 7'b1101001);
    check("t2_mem_rdata", mem_rd[2], 64'hC0DE_0040);
    check("t2_addr1", r_addr[2], 64'h10);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check_flags("t2_wait1", 2, 7'b1000000);
    tick();
    @(negedge clk);
    check_flags("t2_if_rv", 2, 7'b1000100);
    check("t2_if_rdata", if_rd[2], 64'hC0DE_0002);
    tick();
    @(negedge clk);
    check_flags("t2_idle", 2, 7'b0);

    // Test 3: store, dropped request during WAIT, load-back
    do_reset();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h80; mem_wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    check_flags("t3_store_gnt", 2, 7'b0110010);
    check("t3_wdata", r_wdata[2], 64'hDEAD_BEEF);
    check("t3_addr", r_addr[2], 64'h80);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    if_req = 1'b1; if_addr = 64'h10;
    @(negedge clk);
    check_flags("t3_wait", 2, 7'b1000000);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check_flags("t3_ack", 2, 7'b1000001);
    check("t3_ack_rdata", mem_rd[2], 64'h0);
    tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h80;
    @(negedge clk);
    check_flags("t3_load_gnt", 2, 7'b0100010);
    tick();
    mem_req = 1'b0;
    tick();
    @(negedge clk);
    check_flags("t3_load_rv", 2, 7'b1000001);
    check("t3_load_data", mem_rd[2], 64'hDEAD_BEEF);
    tick();

    // Test 4: reset mid-transaction, MEM_LAT=3
    do_reset();
    if_req = 1'b1; if_addr = 64'h40;
    @(negedge clk);
    check_flags("t4_grant", 3, 7'b0101000);
    tick();
    if_req = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check_flags("t4_in_rst", 3, 7'b0);
    tick();
    if_req = 1'b1;
    @(negedge clk);
    check_flags("t4_rst_req", 3, 7'b0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check_flags("t4_release", 3, 7'b0);
    check("t4_no_data", if_rd[3], 64'h0);
    tick();
    @(negedge clk);
    check_flags("t4_regrant", 3, 7'b0101000);
    check("t4_addr", r_addr[3], 64'h40);
    tick();
    if_req = 1'b0;

    // Test 5: MEM_LAT=1 streaming fetch
    do_reset();
    if_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if_addr = 64'h100 + 64'(i * 8);
      @(negedge clk);
      check_flags("t5_flags", 1, (i == 0) ? 7'b0101000 : 7'b1101100);
      check("t5_addr", r_addr[1], 64'h100 + 64'(i * 8));
      if (i > 0) check("t5_rdata", if_rd[1], 64'hC0DE_0020 + 64'(i - 1));
      tick();
    end
    if_req = 1'b0;
    @(negedge clk);
    check_flags("t5_last_rv", 1, 7'b1000100);
    check("t5_last_data", if_rd[1], 64'hC0DE_0024);
    tick();
    @(negedge clk);
    check_flags("t5_idle", 1, 7'b0);

    // Test 6: continuous conflict, MEM_LAT=1
    do_reset();
    if_req = 1'b1; if_addr = 64'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h200;
    prev = 1'b0;
    for (int j = 0; j < 6; j++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = (j % 2 == 0);
`else
      w = 1'b1;
`endif
      @(negedge clk);
      check_flags("t6_arb", 1, {j > 0, 1'b1, 1'b0, !w, (j > 0) && !prev, w, (j > 0) && prev});
      if (j > 0 && prev)  check("t6_mem_data", mem_rd[1], 64'hC0DE_0040);
      if (j > 0 && !prev) check("t6_if_data", if_rd[1], 64'hC0DE_0002);
      prev = w;
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters: port 0 is the instruction fetch stage, port 1 is the MEM-stage load/store.
- Sits between the pipeline and the unified memory macro.
- Sequences one outstanding transaction at a time with a fixed RAM read latency.
- Issues grants, drives RAM controls, and returns a one-cycle response pulse to the owning port.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MEM_LAT, 2, cycles from RAM issue to valid ram_rdata; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_W  fetch read data
mem_req  in  1  load/store request; held until mem_gnt
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_gnt  out  1  load/store accepted this cycle
mem_rvalid  out  1  load data valid or store ack, one-cycle pulse
mem_rdata  out  DATA_W  load data; 0 on store ack
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after ram_en
busy  out  1  transaction outstanding

Behaviour:
- Reset (reset=0, async): state=IDLE, latency counter=0, owner=0, last_grant=IF. All outputs 0 while reset is low and in the first cycle after release.
- FSM has two states, IDLE and WAIT.
- IDLE, no request: all outputs 0.
- IDLE, request present, grant cycle T:
  - Winner's gnt=1 combinationally in cycle T.
  - ram_en=1; ram_addr/ram_we/ram_wdata driven from the winner combinationally in cycle T.
  - ram_we=1 only for mem_we=1 on port 1; ram_we is always 0 for port 0.
  - Owner is registered, counter loads MEM_LAT, next state=WAIT.
- WAIT: busy=1. Counter decrements each cycle. ram_en=0. Both gnt outputs=0.
- Completion at cycle T+MEM_LAT (counter==1 in WAIT):
  - Owner's rvalid=1 for exactly that cycle.
  - Load: owner's rdata = ram_rdata (pass-through).
  - Store: mem_rdata=0.
  - Non-owner rvalid=0. Rdata outputs are 0 whenever their rvalid=0.
- Back-to-back: the completion cycle also acts as an IDLE arbitration cycle. A pending request may be granted and issued in that same cycle, giving peak throughput of 1 transaction per MEM_LAT cycles. busy stays 1 across a back-to-back handoff.
- Arbitration (default): fixed priority; port 1 (MEM) beats port 0 (IF) on simultaneous requests.
- A requester that deasserts req before gnt is simply dropped; no error is raised.
- Requests arriving during WAIT are not granted until the completion cycle.
- MEM_LAT=1: WAIT lasts one cycle and rvalid appears at T+1.
- Reset asserted mid-transaction: outstanding transaction is discarded, no rvalid is issued, FSM returns to IDLE. Any RAM write issued before reset has already occurred.
- Single transaction outstanding: at most one gnt and at most one rvalid in any cycle. if_rvalid and mem_rvalid are never both high.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant goes to the port that did not win the previous grant, tracked by a last_grant register (reset value IF, so the first conflict goes to MEM). Grants without a conflict still update last_grant.
- Undefined: fixed MEM>IF priority; the last_grant register is absent.

Test Plan:
1. MEM_LAT=2; if_req=1, if_addr=0x40 at cycle 5; RAM holds 0x00A0_0093 at 0x40 -> if_gnt=1 at 5, ram_en=1/ram_addr=0x40 at 5, if_rvalid=1 with if_rdata=0x00A0_0093 at 7 only.
2. Simultaneous if_req (0x10) and mem_req load (0x200) at cycle 3, MEM_LAT=2 -> mem_gnt at 3, mem_rvalid at 5; if_gnt at 5 (back-to-back), if_rvalid at 7; busy=1 from cycle 4 through 7.
3. mem_req store, mem_addr=0x80, mem_wdata=0xDEAD_BEEF -> ram_we=1 and ram_wdata=0xDEAD_BEEF in grant cycle; mem_rvalid=1 with mem_rdata=0 two cycles later; a subsequent load from 0x80 returns 0xDEAD_BEEF.
4. MEM_LAT=3; grant at cycle 10; reset driven low at cycle 11, released at 13 -> no rvalid at 13; all outputs 0 from 11 through 13; a new if_req at 14 is granted at 14.
5. MEM_LAT=1 with if_req held continuously -> if_gnt and if_rvalid every cycle from the second cycle onward, addresses consumed in order.
6. With MEM_ARB_ROUND_ROBIN_EN defined, both ports request continuously, MEM_LAT=1 -> grants alternate MEM, IF, MEM, IF…; without the macro, mem_gnt wins every arbitration.
